maxpool_data_split: RTL and testbench
=====================================

Name: maxpool_data_split

Overview:
- Serializes one flat max-pool result vector (M_CO*M_CI*2*2 elements of MAX_BW bits) into a stream of single-element beats. Each beat carries a value, an address and a valid flag, followed by a one-cycle done pulse.
- Sits between wide pooled-result storage and a downstream element-wise consumer, e.g. an off-chip writer or the next layer's loader.
- Its address numbering matches the pooling-combine collector. A stream from this block, fed into that collector, rebuilds the original vector.

Parameters:
- M_CO, 2, number of output channels.
- M_CI, 2, number of input channels.
- MAX_BW, 8, bit width of one pooled element.
- ADDR_BASE, 2, address emitted with element 0. Element i is emitted with address ADDR_BASE+i.
- NUM (localparam), M_CO*M_CI*4, element count per vector.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_vec  in  NUM*MAX_BW  flat vector; element i = in_vec[i*MAX_BW +: MAX_BW].
- in_valid  in  1  load request; in_vec is valid when high.
- in_ready  out  1  high only in IDLE; a load occurs when in_valid & in_ready.
- in_flush  in  1  synchronous abort.
- out_value  out  MAX_BW  current element.
- out_address  out  32  ADDR_BASE + element index.
- out_enable  out  1  beat valid.
- out_ready  in  1  downstream accepts beat.
- out_done  out  1  one-cycle pulse after the last beat is accepted.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset (async, reset_n low):
  - state = IDLE, shadow register = 0, index counter = 0.
  - out_enable = 0, out_done = 0, out_value = 0, out_address = 0, busy = 0, in_ready = 1 (because state is IDLE).
- States: IDLE, SEND, DONE.
- IDLE:
  - in_ready = 1.
  - On a clock edge with in_valid = 1: capture in_vec into the shadow register, set idx = 0, go to SEND.
  - Later changes to in_vec have no effect.
- SEND:
  - out_enable = 1.
  - out_value = shadow[idx*MAX_BW +: MAX_BW]; out_address = ADDR_BASE + idx (zero-extended to 32 bits).
  - Both outputs are driven only from registers and stay stable while out_enable & !out_ready (backpressure holds the beat, no skipped or duplicated elements).
  - On an edge with out_ready = 1 and idx < NUM-1: idx increments.
  - On an edge with out_ready = 1 and idx == NUM-1: go to DONE, idx = 0.
- DONE:
  - out_enable = 0, out_done = 1 for exactly one cycle.
  - Next state is IDLE unconditionally. in_valid is ignored in DONE.
- Latency:
  - Load accepted at edge k → first beat valid in cycle k+1.
  - With out_ready held at 1: NUM beats in cycles k+1 .. k+NUM, out_done in cycle k+NUM+1, in_ready back in cycle k+NUM+2.
- Output gating: when out_enable = 0, out_value and out_address are driven to 0.
- in_valid while busy: ignored, since in_ready = 0. No queueing.
- in_flush (synchronous, highest priority):
  - From any state: next state IDLE, idx = 0, shadow unchanged.
  - No out_done pulse is produced.
  - in_flush together with in_valid in IDLE: nothing is loaded.
  - in_flush together with the last accepted beat: no out_done.
- Reset mid-stream: outputs clear immediately (asynchronously). After release, the block waits in IDLE for a new load.
- Counter width: ceil(log2(NUM)) bits minimum. The counter never exceeds NUM-1 and does not wrap mid-vector.

Test Plan:
- Basic stream: defaults (NUM=16, MAX_BW=8), in_vec element i = 8'h10+i, out_ready tied to 1.
  - Expect 16 consecutive beats with out_value 8'h10..8'h1F and out_address 2..17.
  - Expect out_done one cycle after the last beat, and in_ready high the cycle after that.
- Backpressure: out_ready toggles 1,0,0,1,... → each value is held stable while stalled; the sequence is exactly 16 unique beats in order with no duplicates.
- Ignored reload: pulse in_valid with a different vector during SEND beat 5 → the stream continues with the original data and in_ready stays 0.
- Flush: assert in_flush at beat 7 → out_enable drops the next cycle, no out_done, in_ready = 1. A subsequent load streams from address 2.
- Reset mid-stream: drop reset_n at beat 3 → out_enable = 0 and busy = 0 immediately. After release, a new load of all 8'hAA streams 16 beats correctly.
- Loopback: connect out_value, out_address, out_enable and out_done to the pooling-combine collector → the collector's output vector equals in_vec bit-for-bit when data_done asserts.

Source files
------------

// File: rtl/maxpool_data_split.sv
// maxpool_data_split: serializes one flat max-pool result vector into a
// stream of single-element beats (value + address + valid), then emits a
// one-cycle done pulse. Addresses start at ADDR_BASE and run contiguously.
module maxpool_data_split #(
  parameter int M_CO      = 2,
  parameter int M_CI      = 2,
  parameter int MAX_BW    = 8,
  parameter int ADDR_BASE = 2
) (
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic [M_CO*M_CI*4*MAX_BW-1:0]   in_vec,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic                            in_flush,
  output logic [MAX_BW-1:0]               out_value,
  output logic [31:0]                     out_address,
  output logic                            out_enable,
  input  logic                            out_ready,
  output logic                            out_done,
  output logic                            busy
);

  localparam int NUM   = M_CO * M_CI * 4;
  localparam int IDX_W = (NUM > 1) ? $clog2(NUM) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(NUM - 1);
  localparam logic [31:0]      ADDR_BASE_W = 32'(ADDR_BASE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SEND,
    S_DONE
  } state_t;

  state_t                  state_q, state_d;
  logic [NUM*MAX_BW-1:0]   shadow_q, shadow_d;
  logic [IDX_W-1:0]        idx_q, idx_d;

  // State, shadow copy of the input vector and element index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      shadow_q <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      idx_q    <= idx_d;
    end
  end

  // Next-state logic; flush overrides everything and leaves the shadow intact.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    idx_d    = idx_q;
    if (in_flush) begin
      state_d = S_IDLE;
      idx_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            shadow_d = in_vec;
            idx_d    = '0;
            state_d  = S_SEND;
          end
        end
        S_SEND: begin
          if (out_ready) begin
            if (idx_q == IDX_LAST) begin
              state_d = S_DONE;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Outputs decode purely from registered state; beat fields gated to zero
  // whenever no beat is offered.
  always_comb begin
    in_ready    = (state_q == S_IDLE);
    busy        = (state_q != S_IDLE);
    out_enable  = (state_q == S_SEND);
    out_done    = (state_q == S_DONE);
    out_value   = '0;
    out_address = '0;
    if (state_q == S_SEND) begin
      out_value   = shadow_q[int'(idx_q)*MAX_BW +: MAX_BW];
      out_address = ADDR_BASE_W + 32'(idx_q);
    end
  end

endmodule

// File: tb/tb_maxpool_data_split.sv
// Self-checking bench for maxpool_data_split: randomized vectors and
// backpressure checked against a queue-of-beats reference and a
// behavioural collector that rebuilds the vector from addresses.
module tb_maxpool_data_split;

  localparam int M_CO      = 2;
  localparam int M_CI      = 2;
  localparam int MAX_BW    = 8;
  localparam int ADDR_BASE = 2;
  localparam int NUM       = M_CO * M_CI * 4;
  localparam int VW        = NUM * MAX_BW;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [VW-1:0]     in_vec;
  logic              in_valid;
  logic              in_ready;
  logic              in_flush;
  logic [MAX_BW-1:0] out_value;
  logic [31:0]       out_address;
  logic              out_enable;
  logic              out_ready;
  logic              out_done;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  maxpool_data_split #(
    .M_CO(M_CO), .M_CI(M_CI), .MAX_BW(MAX_BW), .ADDR_BASE(ADDR_BASE)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_vec(in_vec), .in_valid(in_valid),
    .in_ready(in_ready), .in_flush(in_flush), .out_value(out_value),
    .out_address(out_address), .out_enable(out_enable), .out_ready(out_ready),
    .out_done(out_done), .busy(busy)
  );

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < NUM; i++) v[i*MAX_BW +: MAX_BW] = MAX_BW'($urandom);
    return v;
  endfunction

  function automatic logic [MAX_BW-1:0] elem(input logic [VW-1:0] v, input int i);
    return v[i*MAX_BW +: MAX_BW];
  endfunction

  task automatic test_reset();
    reset_n = 1'b0; in_valid = 1'b0; in_flush = 1'b0; out_ready = 1'b0; in_vec = '0;
    #12;
    n_checks++;
    if ({out_enable, out_done, busy, in_ready} !== 4'b0001 || out_value !== '0 || out_address !== '0) begin
      n_fail++;
      $display("FAIL reset_state: en/done/busy/rdy=%b val=%h addr=%0d, required 0001 0 0",
               {out_enable, out_done, busy, in_ready}, out_value, out_address);
    end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_after_reset: rdy=%b busy=%b, required 1 0", in_ready, busy);
    end
  endtask

  // Fixed pattern 0x10+i, out_ready held high: exact latency check.
  task automatic test_basic();
    logic [VW-1:0] v;
    for (int i = 0; i < NUM; i++) v[i*MAX_BW +: MAX_BW] = MAX_BW'(8'h10 + i);
    @(negedge clk);
    in_vec = v; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      n_checks++;
      if (out_enable !== 1'b1 || out_value !== elem(v, i) || out_address !== 32'(ADDR_BASE + i)
          || in_ready !== 1'b0 || out_done !== 1'b0) begin
        n_fail++;
        $display("FAIL basic_beat%0d: en=%b val=%h addr=%0d rdy=%b done=%b, required 1 %h %0d 0 0",
                 i, out_enable, out_value, out_address, in_ready, out_done, elem(v, i), ADDR_BASE + i);
      end
      @(negedge clk);
    end
    n_checks++;
    if (out_done !== 1'b1 || out_enable !== 1'b0 || in_ready !== 1'b0 || out_value !== '0 || out_address !== '0) begin
      n_fail++;
      $display("FAIL basic_done: done=%b en=%b rdy=%b val=%h addr=%0d, required 1 0 0 0 0",
               out_done, out_enable, in_ready, out_value, out_address);
    end
    // in_valid during DONE must be ignored.
    in_vec = rand_vec(); in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_checks++;
    if (out_done !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_back_idle: done=%b rdy=%b busy=%b, required 0 1 0", out_done, in_ready, busy);
    end
  endtask

  // Random data with 1,0,0 pattern then random out_ready; model is a pointer
  // into the expected beat list that advances on each accepted beat.
  task automatic test_backpressure(input int mode);
    logic [VW-1:0] v;
    int ptr, cyc;
    logic r;
    v = rand_vec();
    @(negedge clk);
    in_vec = v; in_valid = 1'b1; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0; in_vec = rand_vec();
    ptr = 0; cyc = 0;
    while (ptr < NUM && cyc < 400) begin
      r = (mode == 0) ? ((cyc % 3) == 0) : 1'($urandom_range(0, 1));
      n_checks++;
      if (out_enable !== 1'b1 || out_value !== elem(v, ptr) || out_address !== 32'(ADDR_BASE + ptr)
          || out_done !== 1'b0) begin
        n_fail++;
        $display("FAIL bp%0d_beat%0d: en=%b val=%h addr=%0d done=%b, required 1 %h %0d 0",
                 mode, ptr, out_enable, out_value, out_address, out_done, elem(v, ptr), ADDR_BASE + ptr);
      end
      out_ready = r;
      @(negedge clk);
      if (r) ptr++;
      cyc++;
    end
    out_ready = 1'b0;
    n_checks++;
    if (ptr != NUM || out_done !== 1'b1 || out_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL bp%0d_done: beats=%0d done=%b en=%b, required %0d 1 0", mode, ptr, out_done, out_enable, NUM);
    end
    @(negedge clk);
  endtask

  // A second load request during beat 5 must not disturb the stream.
  task automatic test_reload_ignored();
    logic [VW-1:0] v;
    v = rand_vec();
    @(negedge clk);
    in_vec = v; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      n_checks++;
      if (out_enable !== 1'b1 || out_value !== elem(v, i) || out_address !== 32'(ADDR_BASE + i) || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL reload_beat%0d: en=%b val=%h addr=%0d rdy=%b, required 1 %h %0d 0",
                 i, out_enable, out_value, out_address, in_ready, elem(v, i), ADDR_BASE + i);
      end
      in_valid = (i == 5);
      in_vec   = (i == 5) ? ~v : v;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n_checks++;
    if (out_done !== 1'b1) begin
      n_fail++;
      $display("FAIL reload_done: done=%b, required 1", out_done);
    end
    @(negedge clk);
  endtask

  // Flush at beat 7, flush with in_valid in IDLE, then a fresh full stream.
  task automatic test_flush();
    logic [VW-1:0] v;
    v = rand_vec();
    @(negedge clk);
    in_vec = v; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (7) @(negedge clk);
    n_checks++;
    if (out_address !== 32'(ADDR_BASE + 7) || out_value !== elem(v, 7)) begin
      n_fail++;
      $display("FAIL flush_beat7: val=%h addr=%0d, required %h %0d", out_value, out_address, elem(v, 7), ADDR_BASE + 7);
    end
    in_flush = 1'b1;
    @(negedge clk);
    in_flush = 1'b0;
    n_checks++;
    if (out_enable !== 1'b0 || out_done !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_abort: en=%b done=%b rdy=%b busy=%b, required 0 0 1 0", out_enable, out_done, in_ready, busy);
    end
    @(negedge clk);
    n_checks++;
    if (out_done !== 1'b0 || out_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_no_done: done=%b en=%b, required 0 0", out_done, out_enable);
    end
    in_flush = 1'b1; in_valid = 1'b1;
    @(negedge clk);
    in_flush = 1'b0; in_valid = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || out_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_blocks_load: busy=%b en=%b, required 0 0", busy, out_enable);
    end
    v = rand_vec();
    in_vec = v; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      n_checks++;
      if (out_enable !== 1'b1 || out_value !== elem(v, i) || out_address !== 32'(ADDR_BASE + i)) begin
        n_fail++;
        $display("FAIL flush_restream%0d: en=%b val=%h addr=%0d, required 1 %h %0d",
                 i, out_enable, out_value, out_address, elem(v, i), ADDR_BASE + i);
      end
      in_flush = (i == NUM - 1);
      @(negedge clk);
    end
    in_flush = 1'b0;
    n_checks++;
    if (out_done !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_last_beat: done=%b rdy=%b, required 0 1", out_done, in_ready);
    end
  endtask

  // Asynchronous reset at beat 3, then an all-0xAA stream.
  task automatic test_reset_midstream();
    logic [VW-1:0] v;
    v = rand_vec();
    @(negedge clk);
    in_vec = v; in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (out_enable !== 1'b0 || busy !== 1'b0 || out_value !== '0 || out_address !== '0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_mid: en=%b busy=%b val=%h addr=%0d rdy=%b, required 0 0 0 0 1",
               out_enable, busy, out_value, out_address, in_ready);
    end
    @(negedge clk); reset_n = 1'b1;
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || out_enable !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_wait_idle: busy=%b en=%b, required 0 0", busy, out_enable);
    end
    v = {NUM{8'hAA}};
    in_vec = v; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < NUM; i++) begin
      n_checks++;
      if (out_enable !== 1'b1 || out_value !== 8'hAA || out_address !== 32'(ADDR_BASE + i)) begin
        n_fail++;
        $display("FAIL rst_aa_beat%0d: en=%b val=%h addr=%0d, required 1 aa %0d",
                 i, out_enable, out_value, out_address, ADDR_BASE + i);
      end
      @(negedge clk);
    end
    n_checks++;
    if (out_done !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_aa_done: done=%b, required 1", out_done);
    end
    @(negedge clk);
  endtask

  // Behavioural collector: place each accepted beat at address-ADDR_BASE and
  // compare the rebuilt vector when done arrives.
  task automatic test_loopback();
    logic [VW-1:0] v, rebuilt;
    int cyc, beats;
    logic r, seen_done;
    for (int n = 0; n < 3; n++) begin
      v = rand_vec(); rebuilt = '0; cyc = 0; beats = 0; seen_done = 1'b0;
      @(negedge clk);
      in_vec = v; in_valid = 1'b1; out_ready = 1'b0;
      @(negedge clk);
      in_valid = 1'b0;
      while (!seen_done && cyc < 400) begin
        r = 1'($urandom_range(0, 1));
        if (out_done === 1'b1) seen_done = 1'b1;
        else if (out_enable === 1'b1 && r) begin
          if (out_address >= 32'(ADDR_BASE) && out_address < 32'(ADDR_BASE + NUM))
            rebuilt[(int'(out_address) - ADDR_BASE)*MAX_BW +: MAX_BW] = out_value;
          beats++;
        end
        out_ready = r;
        if (!seen_done) @(negedge clk);
        cyc++;
      end
      out_ready = 1'b0;
      n_checks++;
      if (!seen_done || beats != NUM || rebuilt !== v) begin
        n_fail++;
        $display("FAIL loopback%0d: done=%b beats=%0d rebuilt=%h, required 1 %0d %h", n, seen_done, beats, rebuilt, NUM, v);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure(0);
    test_backpressure(1);
    test_reload_ignored();
    test_flush();
    test_reset_midstream();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
